// File: rtl/nn_pkg.sv
// Shared types and defaults for the NN fetch responder: FSM states, fetch targets
// and the Avalon word-address helper.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAITDATA,
    FINISH
  } nn_state_e;

  typedef enum logic {
    IMAGE,
    COEFF
  } nn_target_e;

  localparam int NN_IMSIZE = 64;
  localparam int NN_CSIZE  = 2048;
  localparam int NN_LBITS  = 2;

  // Byte address of 32-bit word idx above base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/nn_avm_read_port.sv
// Avalon-MM read handshake: holds read/address through waitrequest and tracks the
// single outstanding read so stray readdatavalid pulses are dropped.
module nn_avm_read_port (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_addr,
  output logic        avm_read,
  output logic [31:0] avm_address,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        accepted,
  output logic        rd_valid,
  output logic [31:0] rd_data
);

  logic outstanding;

  assign accepted = avm_read && !avm_waitrequest;
  assign rd_valid = outstanding && avm_readdatavalid;
  assign rd_data  = avm_readdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= '0;
      outstanding <= 1'b0;
    end else begin
      if (start) begin
        avm_read    <= 1'b1;
        avm_address <= start_addr;
      end else if (accepted) begin
        avm_read <= 1'b0;
      end

      // Clearing on reset is what makes a late response from an aborted read harmless.
      if (accepted) begin
        outstanding <= 1'b1;
      end else if (rd_valid) begin
        outstanding <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nn_fetch_responder.sv
// Fetches an image block or one layer of coefficients from SDRAM over Avalon-MM,
// one word at a time, into image_data or the coefficient buffer write port.
module nn_fetch_responder
  import nn_pkg::*;
#(
  parameter int          IMSIZE     = NN_IMSIZE,
  parameter int          CSIZE      = NN_CSIZE,
  parameter int          LBITS      = NN_LBITS,
  parameter logic [31:0] IMG_BASE   = 32'h0000_0000,
  parameter logic [31:0] COEFF_BASE = 32'h0001_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         get_image,
  input  logic                         get_coeffs,
  input  logic [LBITS-1:0]             layer,
  output logic                         busy,
  output logic                         done,
  output logic [IMSIZE*8-1:0]          image_data,
  output logic                         cw_en,
  output logic [$clog2(CSIZE/4)-1:0]   cw_addr,
  output logic [31:0]                  cw_data,
  output logic [31:0]                  avm_address,
  output logic                         avm_read,
  input  logic                         avm_waitrequest,
  input  logic [31:0]                  avm_readdata,
  input  logic                         avm_readdatavalid
);

  localparam int IM_WORDS = IMSIZE / 4;
  localparam int CO_WORDS = CSIZE / 4;
  localparam int CW_AW    = $clog2(CO_WORDS);
  localparam int MAX_WORDS = (IM_WORDS > CO_WORDS) ? IM_WORDS : CO_WORDS;
  localparam int IDX_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [IDX_W-1:0] IM_LAST = IDX_W'(IM_WORDS - 1);
  localparam logic [IDX_W-1:0] CO_LAST = IDX_W'(CO_WORDS - 1);

  nn_state_e         state;
  nn_target_e        target;
  logic [31:0]       base;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  last_idx;
  logic              coeff_pending;
  logic [LBITS-1:0]  pend_layer;

  logic              issue_start;
  logic [31:0]       issue_addr;
  logic              accepted;
  logic              rd_valid;
  logic [31:0]       rd_data;

  function automatic logic [31:0] coeff_base(input logic [LBITS-1:0] lay);
    return COEFF_BASE + 32'(lay) * 32'(CSIZE);
  endfunction

  // Launch the next read on the same edge the FSM enters ISSUE, so avm_read
  // and the ISSUE state rise and fall together.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    issue_start = 1'b0;
    issue_addr  = '0;
    unique case (state)
      IDLE: begin
        if (get_image) begin
          issue_start = 1'b1;
          issue_addr  = IMG_BASE;
        end else if (get_coeffs) begin
          issue_start = 1'b1;
          issue_addr  = coeff_base(layer);
        end
      end
      WAITDATA: begin
        if (rd_valid && (word_idx != last_idx)) begin
          issue_start = 1'b1;
          issue_addr  = word_addr(base, 32'(word_idx) + 32'd1);
        end
      end
      FINISH: begin
        if (coeff_pending) begin
          issue_start = 1'b1;
          issue_addr  = coeff_base(pend_layer);
        end
      end
      default: ;
    endcase
  end

  nn_avm_read_port u_read_port (
    .clock             (clock),
    .reset             (reset),
    .start             (issue_start),
    .start_addr        (issue_addr),
    .avm_read          (avm_read),
    .avm_address       (avm_address),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .accepted          (accepted),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      target        <= IMAGE;
      base          <= '0;
      word_idx      <= '0;
      last_idx      <= '0;
      coeff_pending <= 1'b0;
      pend_layer    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      image_data    <= '0;
      cw_en         <= 1'b0;
      cw_addr       <= '0;
      cw_data       <= '0;
    end else begin
      done  <= 1'b0;
      cw_en <= 1'b0;

      unique case (state)
        IDLE: begin
          if (get_image) begin
            target        <= IMAGE;
            base          <= IMG_BASE;
            last_idx      <= IM_LAST;
            word_idx      <= '0;
            // A simultaneous coefficient request is parked until the image is done.
            coeff_pending <= get_coeffs;
            pend_layer    <= layer;
            busy          <= 1'b1;
            state         <= ISSUE;
          end else if (get_coeffs) begin
            target   <= COEFF;
            base     <= coeff_base(layer);
            last_idx <= CO_LAST;
            word_idx <= '0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          if (accepted) begin
            state <= WAITDATA;
          end
        end

        WAITDATA: begin
          if (rd_valid) begin
            if (target == IMAGE) begin
              image_data[32*int'(word_idx) +: 32] <= rd_data;
            end else begin
              cw_en   <= 1'b1;
              cw_addr <= CW_AW'(word_idx);
              cw_data <= rd_data;
            end

            if (word_idx == last_idx) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              word_idx <= word_idx + 1'b1;
              state    <= ISSUE;
            end
          end
        end

        FINISH: begin
          if (coeff_pending) begin
            target        <= COEFF;
            base          <= coeff_base(pend_layer);
            last_idx      <= CO_LAST;
            word_idx      <= '0;
            coeff_pending <= 1'b0;
            state         <= ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_fetch_responder.sv
// Self-checking bench for nn_fetch_responder: Avalon slave model, table-driven
// fetch vectors, randomized fetches and hand-written reset/ignore sequences.
module tb_nn_fetch_responder;

  localparam int          IMSIZE     = 64;
  localparam int          CSIZE      = 2048;
  localparam int          IMW        = IMSIZE / 4;
  localparam int          CW         = CSIZE / 4;
  localparam logic [31:0] IMG_BASE   = 32'h0000_0000;
  localparam logic [31:0] COEFF_BASE = 32'h0001_0000;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  get_image = 1'b0;
  logic                  get_coeffs = 1'b0;
  logic [1:0]            layer = '0;
  logic                  busy;
  logic                  done;
  logic [IMSIZE*8-1:0]   image_data;
  logic                  cw_en;
  logic [8:0]            cw_addr;
  logic [31:0]           cw_data;
  logic [31:0]           avm_address;
  logic                  avm_read;
  logic                  avm_waitrequest = 1'b0;
  logic [31:0]           avm_readdata = '0;
  logic                  avm_readdatavalid = 1'b0;

  nn_fetch_responder dut (
    .clock             (clock),
    .reset             (reset),
    .get_image         (get_image),
    .get_coeffs        (get_coeffs),
    .layer             (layer),
    .busy              (busy),
    .done              (done),
    .image_data        (image_data),
    .cw_en             (cw_en),
    .cw_addr           (cw_addr),
    .cw_data           (cw_data),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] salt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (32'h0403_0201 + (a >> 2) * 32'h0404_0404) ^ salt;
  endfunction

  function automatic logic [IMSIZE*8-1:0] exp_image();
    logic [IMSIZE*8-1:0] r;
    logic [31:0] w;
    r = '0;
    for (int k = 0; k < IMSIZE; k++) begin
      w = mem_word(IMG_BASE + 32'(k / 4) * 32'd4);
      r[8*k +: 8] = w[8*(k % 4) +: 8];
    end
    return r;
  endfunction

  // ---------------- Avalon slave model (drives on falling edge) ----------------
  int          wait_cfg = 0;
  int          lat_cfg = 0;
  logic        in_req = 1'b0;
  logic [31:0] hold_addr = '0;
  int          wait_left = 0;
  logic        resp_act = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = '0;
  int          stab_bad = 0;
  logic [31:0] acc_q[$];

  always @(negedge clock) begin
    avm_readdatavalid = 1'b0;
    if (resp_act) begin
      if (resp_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem_word(resp_addr);
        resp_act          = 1'b0;
      end else begin
        resp_cnt--;
      end
    end

    if (in_req) begin
      if (!avm_read || avm_address != hold_addr) stab_bad++;
    end else if (avm_read) begin
      in_req    = 1'b1;
      hold_addr = avm_address;
      wait_left = wait_cfg;
    end

    if (in_req) begin
      if (wait_left > 0) begin
        avm_waitrequest = 1'b1;
        wait_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_req    = 1'b0;
        acc_q.push_back(hold_addr);
        resp_addr = hold_addr;
        resp_cnt  = lat_cfg;
        resp_act  = 1'b1;
      end
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // ---------------- output monitor ----------------
  int         done_cnt = 0;
  int         cw_cnt = 0;
  int         cw_idx = 0;
  int         cw_bad = 0;
  logic [1:0] exp_layer = '0;

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (cw_en) begin
      if (int'(cw_addr) != cw_idx ||
          cw_data != mem_word(COEFF_BASE + 32'(exp_layer) * 32'(CSIZE) + 32'(cw_addr) * 32'd4))
        cw_bad++;
      cw_idx++;
      cw_cnt++;
    end
  end

  // ---------------- test helpers ----------------
  typedef struct {
    string       name;
    logic        img;
    logic        cof;
    logic [1:0]  lay;
    int          wc;
    int          lc;
    int          exp_reads;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_done;
  } vec_t;

  logic [IMSIZE*8-1:0] exp_img = '0;
  int done0, cw0, bad0, stab0;

  function automatic logic [31:0] q_at(input int i);
    if (i >= 0 && i < acc_q.size()) return acc_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    acc_q.delete();
    cw_idx = 0;
    done0  = done_cnt;
    cw0    = cw_cnt;
    bad0   = cw_bad;
    stab0  = stab_bad;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      tick();
      n++;
    end
    check({name, " idle"}, busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int gaps;
    wait_cfg  = v.wc;
    lat_cfg   = v.lc;
    exp_layer = v.lay;
    clear_log();
    get_image  = v.img;
    get_coeffs = v.cof;
    layer      = v.lay;
    tick();
    get_image  = 1'b0;
    get_coeffs = 1'b0;
    check({v.name, " busy_rise"}, busy, 1'b1);
    wait_idle(v.name);
    tick();
    if (v.img) exp_img = exp_image();
    check({v.name, " reads"}, acc_q.size(), v.exp_reads);
    check({v.name, " first_addr"}, q_at(0), v.exp_first);
    check({v.name, " last_addr"}, q_at(acc_q.size() - 1), v.exp_last);
    gaps = 0;
    for (int i = 1; i < acc_q.size(); i++)
      if (acc_q[i] != acc_q[i-1] + 32'd4 && !(v.img && v.cof && i == IMW)) gaps++;
    check({v.name, " addr_step"}, gaps, 0);
    if (v.img && v.cof)
      check({v.name, " coeff_start"}, q_at(IMW), COEFF_BASE + 32'(v.lay) * 32'(CSIZE));
    check({v.name, " done_pulses"}, done_cnt - done0, v.exp_done);
    check({v.name, " cw_pulses"}, cw_cnt - cw0, v.cof ? CW : 0);
    check({v.name, " cw_content"}, cw_bad - bad0, 0);
    check({v.name, " hold_stable"}, stab_bad - stab0, 0);
    check({v.name, " image_data"}, image_data, exp_img);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    vecs[0] = '{"img_basic",    1'b1, 1'b0, 2'd0, 0, 0, IMW,      32'h0000_0000, 32'h0000_003C, 1};
    vecs[1] = '{"coeff_l2",     1'b0, 1'b1, 2'd2, 0, 1, CW,       32'h0001_1000, 32'h0001_17FC, 1};
    vecs[2] = '{"img_wait5",    1'b1, 1'b0, 2'd0, 5, 2, IMW,      32'h0000_0000, 32'h0000_003C, 1};
    vecs[3] = '{"img_coeff_l1", 1'b1, 1'b1, 2'd1, 1, 0, IMW + CW, 32'h0000_0000, 32'h0001_0FFC, 2};
    vecs[4] = '{"coeff_l3",     1'b0, 1'b1, 2'd3, 0, 0, CW,       32'h0001_1800, 32'h0001_1FFC, 1};

    repeat (3) tick();
    reset = 1'b0;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst avm_read", avm_read, 1'b0);
    check("rst avm_address", avm_address, 32'h0);
    check("rst cw_en", cw_en, 1'b0);
    check("rst cw_addr", cw_addr, 9'h0);
    check("rst cw_data", cw_data, 32'h0);
    check("rst image_data", image_data, '0);

    foreach (vecs[vi]) begin
      run_vec(vecs[vi]);
      if (vi == 0) begin
        check("img byte0", image_data[7:0], 8'h01);
        check("img byte63", image_data[511:504], 8'h40);
      end
    end

    // Reset in the middle of an image fetch; the in-flight response arrives later.
    wait_cfg = 0;
    lat_cfg  = 3;
    clear_log();
    get_image = 1'b1;
    tick();
    get_image = 1'b0;
    for (int n = 0; n < 200 && acc_q.size() < 4; n++) tick();
    check("abort reached_word4", acc_q.size(), 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_img = '0;
    repeat (8) tick();
    check("abort busy", busy, 1'b0);
    check("abort no_done", done_cnt - done0, 0);
    check("abort avm_read", avm_read, 1'b0);
    check("abort stale_ignored", image_data, exp_img);
    rv = '{"img_after_abort", 1'b1, 1'b0, 2'd0, 0, 1, IMW, 32'h0000_0000, 32'h0000_003C, 1};
    run_vec(rv);

    // A coefficient request arriving mid-fetch is dropped.
    wait_cfg  = 1;
    lat_cfg   = 1;
    exp_layer = 2'd3;
    clear_log();
    get_image = 1'b1;
    tick();
    get_image = 1'b0;
    repeat (3) tick();
    get_coeffs = 1'b1;
    layer      = 2'd3;
    tick();
    get_coeffs = 1'b0;
    wait_idle("ignore");
    repeat (3) tick();
    check("ignore done_pulses", done_cnt - done0, 1);
    check("ignore reads", acc_q.size(), IMW);
    check("ignore cw_pulses", cw_cnt - cw0, 0);
    check("ignore busy", busy, 1'b0);

    // Randomized fetches against the reference model.
    for (int r = 0; r < 5; r++) begin
      salt = $urandom;
      rv.name = $sformatf("rand%0d", r);
      rv.img  = 1'($urandom_range(0, 1));
      rv.cof  = 1'($urandom_range(0, 1));
      if (!rv.img && !rv.cof) rv.img = 1'b1;
      rv.lay  = 2'($urandom_range(0, 3));
      rv.wc   = $urandom_range(0, 2);
      rv.lc   = $urandom_range(0, 2);
      rv.exp_reads = (rv.img ? IMW : 0) + (rv.cof ? CW : 0);
      rv.exp_first = rv.img ? IMG_BASE : COEFF_BASE + 32'(rv.lay) * 32'(CSIZE);
      rv.exp_last  = rv.cof ? COEFF_BASE + 32'(rv.lay) * 32'(CSIZE) + 32'(CSIZE - 4)
                            : IMG_BASE + 32'(IMSIZE - 4);
      rv.exp_done  = int'(rv.img) + int'(rv.cof);
      run_vec(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_fetch_responder.md
NN_FETCH_RESPONDER -- requirements
Module: nn_fetch_responder

Interface
REQ-001 The block SHALL have parameter IMSIZE, default 64, meaning image bytes per fetch (multiple of 4).
REQ-002 The block SHALL have parameter CSIZE, default 2048, meaning coefficient bytes per layer (multiple of 4).
REQ-003 The block SHALL have parameter LBITS, default 2, meaning layer index width.
REQ-004 The block SHALL have parameters IMG_BASE, default 32'h0000_0000, and COEFF_BASE, default 32'h0001_0000, meaning byte base addresses in SDRAM.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port get_image, input, 1, an image fetch request pulse.
REQ-008 The block SHALL have port get_coeffs, input, 1, a coefficient fetch request pulse.
REQ-009 The block SHALL have port layer, input, LBITS, the layer selected for a coefficient fetch.
REQ-010 The block SHALL have port busy, output, 1, high while any fetch is in progress or pending.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when a fetch completes.
REQ-012 The block SHALL have port image_data, output, IMSIZE*8, the image bytes, with byte k at [8k+7:8k].
REQ-013 The block SHALL have ports cw_en (output, 1), cw_addr (output, clog2(CSIZE/4)) and cw_data (output, 32), forming the coefficient buffer word write port.
REQ-014 The block SHALL have ports avm_address (output, 32), avm_read (output, 1), avm_waitrequest (input, 1), avm_readdata (input, 32) and avm_readdatavalid (input, 1), forming an Avalon-MM read master.

Function
REQ-015 The block SHALL implement FSM states IDLE, ISSUE, WAITDATA and FINISH.
REQ-016 In IDLE, on get_image the block SHALL latch target=IMAGE with base IMG_BASE and word count IMSIZE/4, then go to ISSUE.
REQ-017 In IDLE, on get_coeffs the block SHALL latch target=COEFF, latch layer, use base COEFF_BASE + layer*CSIZE and word count CSIZE/4, then go to ISSUE.
REQ-018 If get_image and get_coeffs are high in the same IDLE cycle, the block SHALL serve the image first, set a coeff-pending flag with layer latched, and start the coefficient fetch in the cycle after the image FINISH.
REQ-019 While busy, the block SHALL ignore get_image and get_coeffs (no queueing beyond REQ-018).
REQ-020 In ISSUE, the block SHALL drive avm_read=1 with avm_address = base + 4*word_idx, and SHALL hold both stable until avm_waitrequest=0, then go to WAITDATA.
REQ-021 The block SHALL allow exactly one outstanding read; avm_read SHALL be 0 outside ISSUE.
REQ-022 In WAITDATA, on avm_readdatavalid the block SHALL store the word: for IMAGE, image_data bytes 4i..4i+3 receive avm_readdata[7:0]..[31:24]; for COEFF, it SHALL pulse cw_en for one cycle with cw_addr=i and cw_data=avm_readdata.
REQ-023 After storing the word, the block SHALL go to FINISH if i is the last word, otherwise increment i and return to ISSUE.
REQ-024 avm_readdatavalid outside WAITDATA SHALL be ignored.
REQ-025 In FINISH, the block SHALL pulse done for one cycle and go to IDLE, or to ISSUE if coeff-pending.
REQ-026 busy SHALL equal (state != IDLE); it SHALL rise the cycle after the accepted request and fall the cycle after done.
REQ-027 image_data SHALL hold its value between fetches; bytes not yet refetched keep their old values during a fetch.
REQ-028 Address arithmetic SHALL be 32-bit unsigned, wrapping modulo 2^32.

Reset
REQ-029 A synchronous reset SHALL force state=IDLE, busy=0, done=0, avm_read=0, avm_address=0, cw_en=0, cw_addr=0, cw_data=0, image_data=0, clear coeff-pending, and clear word_idx.
REQ-030 A reset during a fetch SHALL abort it without a done pulse, and any later avm_readdatavalid from the aborted read SHALL be ignored.

Structure
REQ-031 A shared package nn_pkg SHALL hold the state enum, the target enum (IMAGE, COEFF) and the default IMSIZE, CSIZE and LBITS constants.
REQ-032 The block SHALL use one sub-module, nn_avm_read_port, which holds the ISSUE and waitrequest handshake and the single-outstanding read tracking.

Verification
REQ-033 Scenario 1: send get_image, with memory word n = 32'h0403_0201 + n*32'h0404_0404 and no waitrequest -> 16 reads at addresses 0x0..0x3C, image_data[7:0]=8'h01, image_data[511:504]=8'h40, and a single done pulse.
REQ-034 Scenario 2: send get_coeffs with layer=2 -> the first avm_address is 0x0001_1000, there are 512 cw_en pulses, cw_addr runs 0..511, and the final address is 0x0001_17FC.
REQ-035 Scenario 3: hold avm_waitrequest high for 5 cycles on each read -> avm_address and avm_read stay stable throughout, and the data is correct.
REQ-036 Scenario 4: send get_image and get_coeffs(layer=1) in the same cycle -> the image fetch completes, done pulses, the coefficient fetch starts at 0x0001_0800, and done pulses a second time.
REQ-037 Scenario 5: assert reset after 3 image words -> busy=0 and no done pulse, and a stale readdatavalid is ignored; a following get_image completes correctly.
REQ-038 Scenario 6: send get_coeffs while busy -> the request is ignored, and exactly one done pulse occurs.
